// File: rtl/conv_acc_pkg.sv
// Shared sizes, operand-field positions and the tap multiply helper for conv_acc.
package conv_acc_pkg;

  localparam int NK  = 8;            // kernels
  localparam int KSZ = 9;            // taps per kernel (3x3)
  localparam int DW  = 8;            // weight / pixel width
  localparam int AW  = 20;           // signed accumulator width
  localparam int PW  = 2 * DW + 1;   // signed product width
  localparam int NW  = NK * KSZ;     // total weights

  // Control operand (Rn) field positions
  localparam int RN_IN_BIT   = 0;
  localparam int RN_WEN_LSB  = 1;
  localparam int RN_WEN_MSB  = 7;

  // Highest weight-pair write address that lands in the weight store
  localparam logic [6:0] WEN_LIMIT = 7'd36;

  // Signed weight times unsigned pixel, sign-extended to accumulator width.
  function automatic logic signed [AW-1:0] tap_product(
    input logic signed [DW-1:0] w,
    input logic        [DW-1:0] p
  );
    logic signed [PW-1:0] prod;
    prod = PW'(w) * PW'($signed({1'b0, p}));
    return {{(AW-PW){prod[PW-1]}}, prod};
  endfunction

endpackage

// File: rtl/conv_argmax8.sv
// Combinational signed maximum over the kernel sums; on a tie the lowest index wins.
module conv_argmax8
  import conv_acc_pkg::*;
(
  input  logic signed [AW-1:0] vals [NK],
  output logic        [2:0]    idx
);

  logic signed [AW-1:0] best;

  // Linear scan; strict greater-than keeps the earlier index on equal values
  always_comb begin
    best = vals[0];
    idx  = 3'd0;
    for (int i = 1; i < NK; i++) begin
      if (vals[i] > best) begin
        best = vals[i];
        idx  = 3'(i);
      end else begin
        best = best;
        idx  = idx;
      end
    end
  end

endmodule

// File: rtl/conv_acc.sv
// CPU-attached 3x3 convolution classifier: 8 kernels, 9 taps each, argmax of the sums.
module conv_acc
  import conv_acc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst,
  input  logic [15:0] Rm,
  input  logic [15:0] Rn,
  output logic [3:0]  max_index
);

  localparam logic [3:0] LAST_TAP = 4'(KSZ - 1);
  localparam logic [3:0] FULL     = 4'(KSZ);

  logic signed [DW-1:0] w   [NW];
  logic signed [AW-1:0] acc [NK];
  logic [3:0]           cnt;      // next tap to capture; FULL means window complete
  logic                 done;     // last tap captured on the previous edge
  logic [2:0]           am_idx;
  logic [6:0]           wen;
  logic                 pin;
  logic [6:0]           wa;
  logic [6:0]           we_addr;
  logic                 unused_rn_hi;

  assign wen          = Rn[RN_WEN_MSB:RN_WEN_LSB];
  assign pin          = Rn[RN_IN_BIT];
  assign wa           = wen - 7'd1;
  assign we_addr      = 7'({wa, 1'b0});
  assign unused_rn_hi = ^Rn[15:8];

  conv_argmax8 u_argmax (
    .vals (acc),
    .idx  (am_idx)
  );

  // Weight store, tap accumulation, window counter and registered argmax result
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) begin
        w[i] <= '0;
      end
      for (int f = 0; f < NK; f++) begin
        acc[f] <= '0;
      end
      cnt       <= 4'd0;
      done      <= 1'b0;
      max_index <= 4'd0;
    end else begin
      // Sums are final one edge after the last tap; publish them now
      if (done) begin
        max_index <= {1'b0, am_idx};
        done      <= 1'b0;
      end
      if (wen != 7'd0) begin
        if (wen <= WEN_LIMIT) begin
          w[we_addr]        <= $signed(Rm[7:0]);
          w[we_addr + 7'd1] <= $signed(Rm[15:8]);
        end
        cnt <= 4'd0;
      end else if (pin) begin
        // Pixels past the ninth in one burst are ignored until a gap
        if (cnt < FULL) begin
          for (int f = 0; f < NK; f++) begin
            acc[f] <= ((cnt == 4'd0) ? $signed({AW{1'b0}}) : acc[f])
                      + tap_product(w[7'(KSZ * f) + {3'b000, cnt}], Rm[7:0]);
          end
          cnt <= cnt + 4'd1;
          if (cnt == LAST_TAP) begin
            done <= 1'b1;
          end
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_conv_acc.sv
// Directed plus randomized bench for conv_acc with a window-level reference model.
module tb_conv_acc;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [15:0] Rm;
  logic [15:0] Rn;
  logic [3:0]  max_index;

  int npass  = 0;
  int ntotal = 0;

  // Reference model state: weights, pixels of the current window, final sums
  int  wm [72];
  int  win [$];
  int  sums [8];
  bit  pend;
  int  exp_idx;

  conv_acc dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .Rm        (Rm),
    .Rn        (Rn),
    .max_index (max_index)
  );

  always #5 clk_i = ~clk_i;

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < 8; i++) begin
      if (sums[i] > sums[best]) best = i;
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 72; i++) wm[i] = 0;
    for (int f = 0; f < 8; f++) sums[f] = 0;
    win.delete();
    pend    = 1'b0;
    exp_idx = 0;
  endtask

  // One clock cycle: drive operands, advance the model, compare max_index
  task automatic cyc(input logic [15:0] rm, input logic [15:0] rn);
    int wen;
    Rm = rm;
    Rn = rn;
    @(posedge clk_i);
    #1;
    if (pend) begin
      exp_idx = ref_argmax();
      pend    = 1'b0;
    end
    wen = int'(rn[7:1]);
    if (wen != 0) begin
      if (wen <= 36) begin
        wm[2*(wen-1)]   = int'($signed(rm[7:0]));
        wm[2*(wen-1)+1] = int'($signed(rm[15:8]));
      end
      win.delete();
    end else if (rn[0]) begin
      if (win.size() < 9) begin
        win.push_back(int'(rm[7:0]));
        if (win.size() == 9) begin
          for (int f = 0; f < 8; f++) begin
            sums[f] = 0;
            for (int k = 0; k < 9; k++) sums[f] += wm[9*f+k] * win[k];
          end
          pend = 1'b1;
        end
      end
    end else begin
      win.delete();
    end
    chk("cycle", max_index, 4'(exp_idx));
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    cyc(data, {8'($urandom), 7'(addr), 1'b0});
  endtask

  task automatic pix(input int p);
    cyc({8'($urandom), 8'(p)}, {8'($urandom), 7'd0, 1'b1});
  endtask

  task automatic idle();
    cyc(16'($urandom), {8'($urandom), 8'h00});
  endtask

  initial begin
    int r;
    int n;
    rst = 1'b0;
    Rm  = 16'h0000;
    Rn  = 16'h0000;
    model_reset();
    #12;
    chk("reset", max_index, 4'd0);
    rst = 1'b1;

    // All-zero weights: every sum 0, tie resolves to kernel 0
    for (int p = 10; p <= 18; p++) pix(p);
    idle();
    chk("zero_window", max_index, 4'd0);

    // Single weight at kernel 5 tap 0
    wr(23, 16'h0100);
    for (int p = 1; p <= 9; p++) pix(p);
    chk("latency_hold", max_index, 4'd0);
    idle();
    chk("single_weight", max_index, 4'd5);

    // Kernel 0 all -1 and kernel 1 tap 0 = -1; tie among 2..7
    wr(23, 16'h0000);
    for (int a = 1; a <= 5; a++) wr(a, 16'hFFFF);
    for (int i = 0; i < 9; i++) pix(20);
    idle();
    chk("negative", max_index, 4'd2);

    // Kernel 3 all +1, overlong bursts separated by gaps
    wr(14, 16'h0100);
    for (int a = 15; a <= 18; a++) wr(a, 16'h0101);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) pix(int'($urandom_range(1, 255)));
      idle();
      chk("overlong", max_index, 4'd3);
    end

    // Incomplete window leaves the result alone
    wr(14, 16'h0000);
    wr(10, 16'h0001);
    for (int i = 0; i < 5; i++) pix(200);
    idle();
    chk("incomplete", max_index, 4'd3);
    for (int i = 0; i < 9; i++) pix(int'($urandom_range(1, 255)));
    idle();
    chk("after_incomplete", max_index, 4'd3);

    // Reset in the middle of a window
    for (int i = 0; i < 4; i++) pix(77);
    rst = 1'b0;
    #1;
    chk("rst_mid", max_index, 4'd0);
    model_reset();
    #6;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) pix(int'($urandom_range(0, 255)));
    idle();
    chk("after_rst", max_index, 4'd0);

    // Randomized traffic
    for (int a = 1; a <= 36; a++) wr(a, 16'($urandom));
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        for (int a = 1; a <= 36; a++) wr(a, 16'($urandom));
      end else if (r == 2) begin
        wr(int'($urandom_range(37, 127)), 16'($urandom));
      end else if (r == 3) begin
        for (int i = 0; i < 4; i++) pix(int'($urandom_range(0, 255)));
        wr(int'($urandom_range(1, 36)), 16'($urandom));
        for (int i = 0; i < 9; i++) pix(int'($urandom_range(0, 255)));
        idle();
      end else begin
        n = int'($urandom_range(3, 11));
        for (int i = 0; i < n; i++) pix(int'($urandom_range(0, 255)));
        n = int'($urandom_range(1, 2));
        for (int i = 0; i < n; i++) idle();
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
